eth_rx_cfg_ctrl: RTL and testbench
==================================

Name: eth_rx_cfg_ctrl

Overview:
- Configuration sequencer for the GMII/MII frame receiver.
- Accepts asynchronous-in-time requests for receive enable and link speed (10/100/1000).
- Applies them atomically, only at frame boundaries after a programmable quiet interval.
- Generates the receiver's clk_enable, mii_select and cfg_rx_enable controls, and monitors raw gmii_rx_dv plus the receiver's AXI output so that no frame is truncated or corrupted by a configuration change.

Parameters:
- QUIET_CYCLES, 16: consecutive idle clk cycles required before a pending change is applied; legal range 1..255.
- CLK_DIV_100, 5: clk_enable period in clk cycles at 100M.
- CLK_DIV_10, 50: clk_enable period in clk cycles at 10M.
- INIT_SPEED, 2'b10: speed applied at reset (2'b00=10M, 2'b01=100M, 2'b10/2'b11=1G).

Ports:
- clk  in  1  receive clock.
- rst  in  1  synchronous active-high reset.
- req_rx_enable  in  1  requested receive enable.
- req_speed  in  2  requested speed code.
- gmii_rx_dv  in  1  raw GMII/MII data valid from the PHY.
- mon_tvalid  in  1  receiver m_axis_tvalid, monitored only.
- mon_tlast  in  1  receiver m_axis_tlast, monitored only.
- clk_enable  out  1  receiver clock enable.
- mii_select  out  1  receiver MII nibble mode.
- cfg_rx_enable  out  1  applied receive enable.
- cur_speed  out  2  applied speed code.
- cfg_busy  out  1  request differs from applied config.
- cfg_update  out  1  one-cycle pulse when a change is applied.

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered except cfg_busy.
- Reset values:
  - cfg_rx_enable=0, cur_speed=INIT_SPEED (2'b11 stored as 2'b10).
  - mii_select=(INIT_SPEED==2'b00 or 2'b01), clk_enable=1, cfg_update=0.
  - frame_open=0, quiet_cnt=0, div_cnt=0, state=ACTIVE.
- Reset mid-frame aborts all tracking immediately, with no delayed apply.
- pending = (req_rx_enable != cfg_rx_enable) OR (norm(req_speed) != cur_speed), where norm maps 2'b11 to 2'b10. cfg_busy = pending (combinational). It is 0 while rst is high, because the registered values equal reset values and rst forces that.
- frame_open:
  - Set on mon_tvalid && !mon_tlast.
  - Cleared on mon_tvalid && mon_tlast.
  - A single-beat frame (tvalid && tlast together) leaves it 0.
- idle = !gmii_rx_dv && !frame_open && !(mon_tvalid && !mon_tlast).
- State machine:
  - ACTIVE: quiet_cnt=0. If idle, go to QUIET with quiet_cnt=1.
  - QUIET: if !idle, go to ACTIVE with quiet_cnt=0. Otherwise quiet_cnt increments, saturating at QUIET_CYCLES. When quiet_cnt==QUIET_CYCLES and pending, go to APPLY.
  - APPLY (exactly 1 cycle):
    - Register cfg_rx_enable<=req_rx_enable, cur_speed<=norm(req_speed), mii_select<=(norm!=2'b10), div_cnt<=0, cfg_update<=1.
    - Request inputs are sampled in this cycle.
    - Next state is QUIET (quiet_cnt kept saturated) if idle, else ACTIVE.
- Apply latency: with the link already quiet and saturated, a request change at cycle N gives state APPLY at N+1 and new outputs with cfg_update=1 at N+2.
- All fields change together, never partially.
- A request that changes again before APPLY is simply re-evaluated. A request that returns to the applied value before APPLY causes no update.
- gmii_rx_dv rising in the same cycle the FSM would enter APPLY cancels the apply: idle has priority and the FSM goes to ACTIVE.
- clk_enable generation:
  - 1G: constant 1.
  - 100M/10M: clk_enable=(div_cnt==0). div_cnt increments each cycle and wraps at CLK_DIV_x-1.
  - The first enable pulse falls on the cycle after cfg_update, because div_cnt is restarted at 0 on apply.
  - A divisor of 1 yields constant 1.
- Quiet counting uses raw clk cycles regardless of clk_enable.

Test Plan:
1. Reset with INIT_SPEED=2'b10; hold gmii_rx_dv=0; raise req_rx_enable at cycle 3 -> cfg_busy=1 from cycle 3, cfg_rx_enable=1 and cfg_update=1 exactly 1 cycle at cycle QUIET_CYCLES+2 after reset release (quiet saturation) or N+2 if already saturated.
2. With rx enabled at 1G, drive a 64-byte frame (dv high 72 cycles), request speed 2'b01 mid-frame -> no change until dv low and tlast seen plus 16 idle cycles; then cur_speed=01, mii_select=1, clk_enable pulses 1-in-5 starting the cycle after cfg_update.
3. Speed 2'b00 applied -> clk_enable high on cycles 0, 50, 100 after apply; switch back to 2'b10 -> clk_enable constant 1 from the apply cycle.
4. Idle link, request disable then re-enable before QUIET saturates -> no cfg_update, cfg_busy returns to 0.
5. gmii_rx_dv pulses high for 1 cycle at quiet_cnt=15 with pending -> counter restarts, apply occurs 16 idle cycles later.
6. Assert rst during pending with frame_open=1 -> the next cycle has all outputs at reset values and cfg_update=0; req_speed=2'b11 after reset -> cur_speed=2'b10, pending=0.

Source files
------------

// File: rtl/eth_rx_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// eth_rx_cfg_ctrl
//
// Configuration sequencer for the GMII/MII frame receiver. It takes requested
// receive-enable and link-speed settings, which may change at any time, and
// applies them together only at a frame boundary. The link must first have
// been quiet for QUIET_CYCLES consecutive clk cycles, so that no frame is
// truncated or corrupted by the change. It also generates the receiver's
// clock enable and MII nibble-mode select.
//
// Ports:
//   clk            in   receive clock
//   rst            in   synchronous active-high reset
//   req_rx_enable  in   requested receive enable
//   req_speed      in   requested speed (00=10M, 01=100M, 10/11=1G)
//   gmii_rx_dv     in   raw GMII/MII data valid from the PHY
//   mon_tvalid     in   receiver m_axis_tvalid (observed, never driven)
//   mon_tlast      in   receiver m_axis_tlast (observed, never driven)
//   clk_enable     out  receiver clock enable
//   mii_select     out  receiver MII nibble mode
//   cfg_rx_enable  out  applied receive enable
//   cur_speed      out  applied speed code (11 is stored as 10)
//   cfg_busy       out  request differs from applied config (combinational)
//   cfg_update     out  one-cycle pulse in the first cycle of a new config
//   dbg_state      out  sequencer state (0=ACTIVE, 1=QUIET, 2=APPLY)
//
// The AXI-Stream inputs are observe-only: a beat exists in any cycle where
// mon_tvalid is high (the receiver output has no backpressure), and a beat
// with mon_tlast high closes the frame.
// ---------------------------------------------------------------------------
module eth_rx_cfg_ctrl #(
    parameter int         QUIET_CYCLES = 16,
    parameter int         CLK_DIV_100  = 5,
    parameter int         CLK_DIV_10   = 50,
    parameter logic [1:0] INIT_SPEED   = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_rx_enable,
    input  logic [1:0] req_speed,
    input  logic       gmii_rx_dv,
    input  logic       mon_tvalid,
    input  logic       mon_tlast,
    output logic       clk_enable,
    output logic       mii_select,
    output logic       cfg_rx_enable,
    output logic [1:0] cur_speed,
    output logic       cfg_busy,
    output logic       cfg_update,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_QUIET  = 2'd1,
        ST_APPLY  = 2'd2
    } state_t;

    localparam logic [1:0] SPD_10  = 2'b00;
    localparam logic [1:0] SPD_100 = 2'b01;
    localparam logic [1:0] SPD_1G  = 2'b10;

    localparam logic [1:0] INIT_NORM   = (INIT_SPEED == 2'b11) ? SPD_1G : INIT_SPEED;
    localparam logic [7:0] QUIET_SAT   = 8'(QUIET_CYCLES);
    localparam logic [7:0] DIV10_LAST  = 8'(CLK_DIV_10 - 1);
    localparam logic [7:0] DIV100_LAST = 8'(CLK_DIV_100 - 1);

    // Terminal divider count for a speed; 0 means clk_enable is constant 1
    // (1G, or a divisor of 1).
    function automatic logic [7:0] div_last(input logic [1:0] spd);
        case (spd)
            SPD_10:  div_last = DIV10_LAST;
            SPD_100: div_last = DIV100_LAST;
            default: div_last = 8'd0;
        endcase
    endfunction

    state_t     r_state;
    logic [7:0] r_quiet_cnt;
    logic [7:0] r_div_cnt;
    logic       r_frame_open;
    logic       r_cfg_rx_enable;
    logic [1:0] r_cur_speed;
    logic       r_mii_select;
    logic       r_clk_enable;
    logic       r_cfg_update;

    logic [1:0] w_req_norm;
    logic       w_pending;
    logic       w_idle;
    logic [7:0] w_div_last;

    assign w_req_norm = (req_speed == 2'b11) ? SPD_1G : req_speed;
    assign w_pending  = (req_rx_enable != r_cfg_rx_enable) || (w_req_norm != r_cur_speed);

    // A beat opening a frame counts as activity in its own cycle, before
    // r_frame_open has caught up with it.
    assign w_idle     = !gmii_rx_dv && !r_frame_open && !(mon_tvalid && !mon_tlast);
    assign w_div_last = div_last(r_cur_speed);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_ACTIVE;
            r_quiet_cnt     <= 8'd0;
            r_div_cnt       <= 8'd0;
            r_frame_open    <= 1'b0;
            r_cfg_rx_enable <= 1'b0;
            r_cur_speed     <= INIT_NORM;
            r_mii_select    <= (INIT_NORM != SPD_1G);
            r_clk_enable    <= 1'b1;
            r_cfg_update    <= 1'b0;
        end else begin
            // A single-beat frame (tvalid and tlast together) leaves it closed.
            if (mon_tvalid) begin
                r_frame_open <= !mon_tlast;
            end

            r_cfg_update <= 1'b0;

            // Free-running divider; clk_enable is the registered wrap marker,
            // so it rises the cycle after the counter sits at zero.
            if (r_div_cnt >= w_div_last) begin
                r_div_cnt <= 8'd0;
            end else begin
                r_div_cnt <= r_div_cnt + 8'd1;
            end
            r_clk_enable <= (r_div_cnt == 8'd0);

            case (r_state)
                ST_ACTIVE: begin
                    r_quiet_cnt <= 8'd0;
                    if (w_idle) begin
                        r_state     <= ST_QUIET;
                        r_quiet_cnt <= 8'd1;
                    end
                end

                ST_QUIET: begin
                    // Fresh activity wins over a due apply.
                    if (!w_idle) begin
                        r_state     <= ST_ACTIVE;
                        r_quiet_cnt <= 8'd0;
                    end else begin
                        if (r_quiet_cnt != QUIET_SAT) begin
                            r_quiet_cnt <= r_quiet_cnt + 8'd1;
                        end
                        if ((r_quiet_cnt == QUIET_SAT) && w_pending) begin
                            r_state <= ST_APPLY;
                        end
                    end
                end

                ST_APPLY: begin
                    // Requests are re-sampled here; one that has reverted to
                    // the applied value produces no update.
                    if (w_pending) begin
                        r_cfg_rx_enable <= req_rx_enable;
                        r_cur_speed     <= w_req_norm;
                        r_mii_select    <= (w_req_norm != SPD_1G);
                        r_div_cnt       <= 8'd0;
                        // Slow speeds stay low in the update cycle and pulse
                        // on the next one; 1G is high immediately.
                        r_clk_enable    <= (div_last(w_req_norm) == 8'd0);
                        r_cfg_update    <= 1'b1;
                    end
                    if (w_idle) begin
                        r_state <= ST_QUIET;
                    end else begin
                        r_state     <= ST_ACTIVE;
                        r_quiet_cnt <= 8'd0;
                    end
                end

                default: begin
                    r_state     <= ST_ACTIVE;
                    r_quiet_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign clk_enable    = r_clk_enable;
    assign mii_select    = r_mii_select;
    assign cfg_rx_enable = r_cfg_rx_enable;
    assign cur_speed     = r_cur_speed;
    assign cfg_update    = r_cfg_update;
    assign cfg_busy      = w_pending && !rst;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_eth_rx_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_cfg_ctrl
//
// Self-checking bench for eth_rx_cfg_ctrl with default parameters
// (QUIET_CYCLES=16, CLK_DIV_100=5, CLK_DIV_10=50, INIT_SPEED=2'b10).
// Each requested configuration change pushes {update cycle, rx_enable, speed,
// mii_select} onto exp_q; a monitor pops and compares on every cfg_update.
// A cycle is numbered by cyc, which steps on each rising clk edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_rx_cfg_ctrl;

    localparam int QC = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_rx_enable = 1'b0;
    logic [1:0] req_speed = 2'b10;
    logic       gmii_rx_dv = 1'b0;
    logic       mon_tvalid = 1'b0;
    logic       mon_tlast = 1'b0;
    logic       clk_enable;
    logic       mii_select;
    logic       cfg_rx_enable;
    logic [1:0] cur_speed;
    logic       cfg_busy;
    logic       cfg_update;
    logic [1:0] dbg_state;

    eth_rx_cfg_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_rx_enable (req_rx_enable),
        .req_speed     (req_speed),
        .gmii_rx_dv    (gmii_rx_dv),
        .mon_tvalid    (mon_tvalid),
        .mon_tlast     (mon_tlast),
        .clk_enable    (clk_enable),
        .mii_select    (mii_select),
        .cfg_rx_enable (cfg_rx_enable),
        .cur_speed     (cur_speed),
        .cfg_busy      (cfg_busy),
        .cfg_update    (cfg_update),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int at_cyc, input logic rx, input logic [1:0] spd, input logic mii);
        exp_q.push_back({16'(at_cyc), rx, spd, mii});
    endtask

    // Advance to the drive point (just after the rising edge) of cycle c.
    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_update(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (cfg_update === 1'b1) seen = 1'b1;
        end
        if (!seen) check_eq("update_timeout", 32'(cfg_update), 32'd1);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_rx_en"},  32'(cfg_rx_enable), 32'd0);
        check_eq({pfx, "_speed"},  32'(cur_speed),     32'd2);
        check_eq({pfx, "_mii"},    32'(mii_select),    32'd0);
        check_eq({pfx, "_clk_en"}, 32'(clk_enable),    32'd1);
        check_eq({pfx, "_update"}, 32'(cfg_update),    32'd0);
        check_eq({pfx, "_busy"},   32'(cfg_busy),      32'd0);
        check_eq({pfx, "_state"},  32'(dbg_state),     32'd0);
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (cfg_update === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_update", 32'(cfg_update), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("upd_cycle", 32'(cyc[15:0]),    32'(mon_e[19:4]));
                check_eq("upd_rx_en", 32'(cfg_rx_enable), 32'(mon_e[3]));
                check_eq("upd_speed", 32'(cur_speed),     32'(mon_e[2:1]));
                check_eq("upd_mii",   32'(mii_select),    32'(mon_e[0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r, f, n, d, a, start;

        // Reset values while rst is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst0");

        // 1: enable receive shortly after reset; quiet must saturate first.
        goto_cycle(cyc + 1);
        rst = 1'b0;
        r = cyc;
        goto_cycle(r + 3);
        req_rx_enable = 1'b1;
        push_exp(r + QC + 2, 1'b1, 2'b10, 1'b0);
        @(negedge clk);
        check_eq("t1_busy", 32'(cfg_busy), 32'd1);
        wait_update(40);

        // 2: 72-cycle frame with the AXI side lagging; speed request mid-frame.
        goto_cycle(cyc + 1);
        f = cyc;
        for (int i = 0; i < 80; i++) begin
            gmii_rx_dv = (i < 72);
            mon_tvalid = (i >= 10);
            mon_tlast  = (i == 79);
            if (i == 30) begin
                req_speed = 2'b01;
                // Last busy cycle is f+79 (tlast); first idle cycle f+80.
                push_exp(f + 80 + QC + 2, 1'b1, 2'b01, 1'b1);
            end
            if (i == 40) begin
                @(negedge clk);
                check_eq("t2_busy_midframe",  32'(cfg_busy),  32'd1);
                check_eq("t2_speed_midframe", 32'(cur_speed), 32'd2);
            end
            @(posedge clk);
            #1;
        end
        mon_tvalid = 1'b0;
        mon_tlast  = 1'b0;
        wait_update(60);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            check_eq("t2_clk_en_100m", 32'(clk_enable), 32'((k > 0) && ((k - 1) % 5 == 0)));
        end

        // 3: 10M then back to 1G on a saturated quiet link.
        goto_cycle(cyc + 1);
        n = cyc;
        req_speed = 2'b00;
        push_exp(n + 2, 1'b1, 2'b00, 1'b1);
        wait_update(10);
        for (int k = 0; k < 102; k++) begin
            if (k > 0) @(negedge clk);
            check_eq("t3_clk_en_10m", 32'(clk_enable), 32'((k > 0) && ((k - 1) % 50 == 0)));
        end
        goto_cycle(cyc + 1);
        n = cyc;
        req_speed = 2'b10;
        push_exp(n + 2, 1'b1, 2'b10, 1'b0);
        wait_update(10);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            check_eq("t3_clk_en_1g", 32'(clk_enable), 32'd1);
        end

        // 4: disable then re-enable before quiet saturates -> no update.
        goto_cycle(cyc + 1);
        d = cyc;
        gmii_rx_dv = 1'b1;
        goto_cycle(d + 1);
        gmii_rx_dv = 1'b0;
        goto_cycle(d + 3);
        req_rx_enable = 1'b0;
        @(negedge clk);
        check_eq("t4_busy_set", 32'(cfg_busy), 32'd1);
        goto_cycle(d + 8);
        req_rx_enable = 1'b1;
        @(negedge clk);
        check_eq("t4_busy_clear", 32'(cfg_busy), 32'd0);
        goto_cycle(d + 40);
        @(negedge clk);
        check_eq("t4_busy_late", 32'(cfg_busy),      32'd0);
        check_eq("t4_rx_en",     32'(cfg_rx_enable), 32'd1);
        check_eq("t4_state",     32'(dbg_state),     32'd1);

        // 5: dv glitch at quiet_cnt=15 restarts the quiet interval.
        goto_cycle(cyc + 1);
        d = cyc;
        gmii_rx_dv = 1'b1;
        goto_cycle(d + 1);
        start = cyc;
        gmii_rx_dv = 1'b0;
        req_speed = 2'b01;
        push_exp(start + 16 + QC + 2, 1'b1, 2'b01, 1'b1);
        goto_cycle(start + 15);
        gmii_rx_dv = 1'b1;
        @(negedge clk);
        check_eq("t5_state_q15", 32'(dbg_state), 32'd1);
        goto_cycle(start + 16);
        gmii_rx_dv = 1'b0;
        @(negedge clk);
        check_eq("t5_state_restart", 32'(dbg_state), 32'd0);
        wait_update(40);

        // 5b: dv rising in the cycle an apply is due cancels it.
        goto_cycle(cyc + 1);
        n = cyc;
        req_speed = 2'b10;
        gmii_rx_dv = 1'b1;
        push_exp(n + 1 + QC + 2, 1'b1, 2'b10, 1'b0);
        goto_cycle(n + 1);
        gmii_rx_dv = 1'b0;
        wait_update(40);

        // 6: reset with a pending request and an open frame.
        goto_cycle(cyc + 1);
        a = cyc;
        req_speed = 2'b01;
        mon_tvalid = 1'b1;
        mon_tlast = 1'b0;
        goto_cycle(a + 1);
        mon_tvalid = 1'b0;
        rst = 1'b1;
        goto_cycle(a + 2);
        @(negedge clk);
        check_reset_vals("rst1");
        goto_cycle(a + 3);
        rst = 1'b0;
        r = cyc;
        req_speed = 2'b11;
        req_rx_enable = 1'b0;
        @(negedge clk);
        check_eq("t6_busy_speed11", 32'(cfg_busy),  32'd0);
        check_eq("t6_speed",        32'(cur_speed), 32'd2);
        // The frame tracker must have been cleared, or this never applies.
        goto_cycle(r + 30);
        req_rx_enable = 1'b1;
        push_exp(r + 32, 1'b1, 2'b10, 1'b0);
        wait_update(10);

        goto_cycle(cyc + 5);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
